// File: rtl/disp_scan_ctrl.sv
// ============================================================================
// Module  : disp_scan_ctrl
// Brief   : Multiplexed seven-segment scan controller with a double-buffered
//           load handshake, an anti-ghosting guard interval and leading-zero
//           suppression. Optional per-digit blink: define DISP_SCAN_BLINK_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module disp_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      disp_on,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    input  logic                      load_lzs,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [3:0]                hex_nibble,
    output logic [NUM_DIGITS-1:0]     digit_sel_n,
    output logic                      seg_blank,
    output logic                      frame_start
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int VAL_W  = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TICK_W-1:0] SLOT_LAST  = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0] GUARD_LAST = TICK_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_DRIVE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TICK_W-1:0]   tick_q, tick_d;

    logic [VAL_W-1:0]    active_q, active_d;
    logic                active_lzs_q, active_lzs_d;
    logic [VAL_W-1:0]    pend_val_q, pend_val_d;
    logic                pend_lzs_q, pend_lzs_d;
    logic                pending_q, pending_d;
    logic                load_ready_q, load_ready_d;

    logic [3:0]            hex_q, hex_d;
    logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
    logic                  blank_q, blank_d;
    logic                  fstart_q, fstart_d;

    logic                  wrap;
    logic                  frame_pulse;
    logic                  xfer;
    logic                  commit;
    logic [3:0]            cur_nibble;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  zero_run;
    logic                  blink_off;

    // Slot boundaries: the last DRIVE cycle of the top digit is the frame wrap.
    assign wrap        = (state_q == S_DRIVE) && (tick_q == SLOT_LAST) && (idx_q == IDX_LAST);
    assign frame_pulse = (state_q == S_GUARD) && (idx_q == '0) && (tick_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tick_d   = tick_q;
        hex_d    = cur_nibble;
        sel_n_d  = '1;
        blank_d  = 1'b1;
        fstart_d = frame_pulse;

        case (state_q)
            S_IDLE: begin
                idx_d  = '0;
                tick_d = '0;
                if (disp_on) begin
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == GUARD_LAST) begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                sel_n_d = ~(NUM_DIGITS'(1) << idx_q);
                blank_d = suppress[idx_q] | blink_off;
                if (tick_q == SLOT_LAST) begin
                    tick_d  = '0;
                    state_d = S_GUARD;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                tick_d  = '0;
            end
        endcase

        if (!disp_on) begin
            state_d = S_IDLE;
            idx_d   = '0;
            tick_d  = '0;
        end
    end

    // Shared decoder feed: nibble of the digit currently owning the slot.
    always_comb begin
        cur_nibble = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = active_q[i*4 +: 4];
            end
        end
    end

    // Scan from the top digit down; a digit is blank while everything above is zero.
    always_comb begin
        zero_run = 1'b1;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (active_q[i*4 +: 4] == 4'd0);
            if (i != 0) begin
                suppress[i] = active_lzs_q & zero_run;
            end
        end
    end

    // Pending buffer only moves to the active one at a frame wrap (or in IDLE).
    assign xfer   = load_valid & load_ready_q;
    assign commit = pending_q & (wrap | (state_q == S_IDLE));

    always_comb begin
        pend_val_d   = pend_val_q;
        pend_lzs_d   = pend_lzs_q;
        pending_d    = pending_q;
        active_d     = active_q;
        active_lzs_d = active_lzs_q;
        if (commit) begin
            active_d     = pend_val_q;
            active_lzs_d = pend_lzs_q;
            pending_d    = 1'b0;
        end else if (xfer) begin
            pend_val_d = load_value;
            pend_lzs_d = load_lzs;
            pending_d  = 1'b1;
        end
        load_ready_d = ~pending_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q     <= '0;
            active_lzs_q <= 1'b0;
            pend_val_q   <= '0;
            pend_lzs_q   <= 1'b0;
            pending_q    <= 1'b0;
            load_ready_q <= 1'b1;
            hex_q        <= 4'd0;
            sel_n_q      <= '1;
            blank_q      <= 1'b1;
            fstart_q     <= 1'b0;
        end else begin
            active_q     <= active_d;
            active_lzs_q <= active_lzs_d;
            pend_val_q   <= pend_val_d;
            pend_lzs_q   <= pend_lzs_d;
            pending_q    <= pending_d;
            load_ready_q <= load_ready_d;
            hex_q        <= hex_d;
            sel_n_q      <= sel_n_d;
            blank_q      <= blank_d;
            fstart_q     <= fstart_d;
        end
    end

`ifdef DISP_SCAN_BLINK_EN
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               phase_q, phase_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (state_q == S_IDLE) begin
            frame_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (frame_pulse) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_off = phase_q & blink_mask[idx_q];
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask ^ BLINK_FRAMES[0];
    assign blink_off    = 1'b0;
`endif

    assign load_ready  = load_ready_q;
    assign hex_nibble  = hex_q;
    assign digit_sel_n = sel_n_q;
    assign seg_blank   = blank_q;
    assign frame_start = fstart_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
// ============================================================================
// Module  : tb_disp_scan_ctrl
// Brief   : Directed, table-driven self-checking bench for disp_scan_ctrl
//           (4 digits, 8-cycle slots, 2-cycle guard, 2-frame blink).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_on;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic        load_lzs;
    logic [3:0]  blink_mask;
    logic [3:0]  hex_nibble;
    logic [3:0]  digit_sel_n;
    logic        seg_blank;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] val;
        logic        lzs;
        logic [3:0]  blank;   // expected seg_blank per digit during DRIVE
    } vec_t;

    vec_t vecs[7];

    disp_scan_ctrl #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .GUARD_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_on     (disp_on),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .load_lzs    (load_lzs),
        .blink_mask  (blink_mask),
        .hex_nibble  (hex_nibble),
        .digit_sel_n (digit_sel_n),
        .seg_blank   (seg_blank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string name);
        for (int i = 0; i < 80; i++) begin
            tick();
            if (frame_start) break;
        end
        chk(name, frame_start, 1);
    endtask

    task automatic wait_sel(input logic [3:0] sel, input string name);
        for (int i = 0; i < 80; i++) begin
            tick();
            if (digit_sel_n == sel) break;
        end
        chk(name, digit_sel_n, sel);
    endtask

    // Current sample must be the one where frame_start is high.
    task automatic check_frame(input logic [15:0] nibs, input logic [3:0] blanks, input string tag);
        int         slot;
        int         pos;
        logic [3:0] sel_exp;
        for (int c = 0; c < 32; c++) begin
            slot = c / 8;
            pos  = c % 8;
            if (c > 0) tick();
            if (pos == 0) begin
                chk($sformatf("%s_d%0d_guard_sel", tag, slot), digit_sel_n, 4'hF);
                chk($sformatf("%s_d%0d_guard_blank", tag, slot), seg_blank, 1);
                chk($sformatf("%s_d%0d_guard_nib", tag, slot), hex_nibble, nibs[slot*4 +: 4]);
            end else if (pos == 4) begin
                sel_exp = ~(4'b0001 << slot);
                chk($sformatf("%s_d%0d_sel", tag, slot), digit_sel_n, sel_exp);
                chk($sformatf("%s_d%0d_nib", tag, slot), hex_nibble, nibs[slot*4 +: 4]);
                chk($sformatf("%s_d%0d_blank", tag, slot), seg_blank, blanks[slot]);
            end
        end
    endtask

    task automatic load_and_check(input logic [15:0] v, input logic lzs, input logic [3:0] blanks,
                                  input string tag);
        chk({tag, "_ready_pre"}, load_ready, 1);
        load_valid = 1'b1;
        load_value = v;
        load_lzs   = lzs;
        tick();
        load_valid = 1'b0;
        load_value = ~v;
        load_lzs   = ~lzs;
        chk({tag, "_ready_low"}, load_ready, 0);
        for (int i = 0; i < 48; i++) begin
            tick();
            if (load_ready) break;
        end
        chk({tag, "_ready_back"}, load_ready, 1);
        tick();
        chk({tag, "_fs_after_commit"}, frame_start, 1);
        check_frame(v, blanks, tag);
    endtask

    initial begin
        int         cnt;
        logic [3:0] sel_exp;
        logic       blink_exp;

        vecs[0] = '{val: 16'h1234, lzs: 1'b0, blank: 4'b0000};
        vecs[1] = '{val: 16'h0050, lzs: 1'b1, blank: 4'b1100};
        vecs[2] = '{val: 16'h0000, lzs: 1'b1, blank: 4'b1110};
        vecs[3] = '{val: 16'h0000, lzs: 1'b0, blank: 4'b0000};
        vecs[4] = '{val: 16'h0F00, lzs: 1'b1, blank: 4'b1000};
        vecs[5] = '{val: 16'hA0B0, lzs: 1'b1, blank: 4'b0000};
        vecs[6] = '{val: 16'h0001, lzs: 1'b1, blank: 4'b1110};

        reset      = 1'b1;
        disp_on    = 1'b1;
        load_valid = 1'b0;
        load_value = 16'h0;
        load_lzs   = 1'b0;
        blink_mask = 4'b0000;

        // Reset state and first-frame timing
        tick(); tick(); tick();
        chk("rst_sel", digit_sel_n, 4'hF);
        chk("rst_blank", seg_blank, 1);
        chk("rst_ready", load_ready, 1);
        chk("rst_fs", frame_start, 0);
        chk("rst_nib", hex_nibble, 0);
        reset = 1'b0;
        tick();
        chk("e1_fs", frame_start, 0);
        tick();
        chk("e2_fs", frame_start, 1);
        chk("e2_sel", digit_sel_n, 4'hF);
        for (int k = 3; k <= 12; k++) begin
            tick();
            if (k >= 4 && k <= 9)  sel_exp = 4'b1110;
            else if (k == 12)      sel_exp = 4'b1101;
            else                   sel_exp = 4'b1111;
            chk($sformatf("e%0d_sel", k), digit_sel_n, sel_exp);
            if (k == 5) chk("e5_blank", seg_blank, 0);
        end
        cnt = 12;
        for (int i = 0; i < 40; i++) begin
            tick();
            cnt++;
            if (frame_start) break;
        end
        chk("frame_period", cnt - 2, 32);

        // Load while digit 2 is driven; a second offer during pending is ignored
        wait_sel(4'b1011, "wait_d2");
        load_valid = 1'b1;
        load_value = 16'h1234;
        load_lzs   = 1'b0;
        tick();
        load_value = 16'hFFFF;
        load_lzs   = 1'b1;
        chk("pend_ready_low", load_ready, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (load_ready) break;
        end
        load_valid = 1'b0;
        chk("pend_ready_back", load_ready, 1);
        tick();
        chk("commit_at_wrap_fs", frame_start, 1);
        check_frame(16'h1234, 4'b0000, "v1234");
        chk("post_1234_ready", load_ready, 1);

        // Table of values and expected suppression
        for (int v = 0; v < 7; v++) begin
            load_and_check(vecs[v].val, vecs[v].lzs, vecs[v].blank, $sformatf("vec%0d", v));
        end

        // Drop display on digit 2, load while idle, restart
        wait_sel(4'b1011, "wait_d2_off");
        disp_on = 1'b0;
        tick();
        tick();
        chk("off_sel", digit_sel_n, 4'hF);
        chk("off_blank", seg_blank, 1);
        load_valid = 1'b1;
        load_value = 16'h0042;
        load_lzs   = 1'b0;
        tick();
        load_valid = 1'b0;
        load_value = 16'hBEEF;
        chk("idle_ready_low", load_ready, 0);
        tick();
        chk("idle_commit_ready", load_ready, 1);
        disp_on = 1'b1;
        tick();
        chk("restart_fs_e1", frame_start, 0);
        tick();
        chk("restart_fs_e2", frame_start, 1);
        check_frame(16'h0042, 4'b0000, "idle_load");

        // Blink on digit 0 across six frames from a fresh IDLE exit
        disp_on = 1'b0;
        tick(); tick(); tick();
        blink_mask = 4'b0001;
        disp_on    = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            wait_fs($sformatf("blink_fs%0d", f));
            tick(); tick(); tick(); tick();
`ifdef DISP_SCAN_BLINK_EN
            blink_exp = ((f / 2) % 2) == 1;
`else
            blink_exp = 1'b0;
`endif
            chk($sformatf("blink_f%0d_d0", f), seg_blank, blink_exp);
            for (int i = 0; i < 8; i++) tick();
            chk($sformatf("blink_f%0d_d1", f), seg_blank, 0);
        end
        blink_mask = 4'b0000;

        // Reset during DRIVE with a pending value
        wait_sel(4'b1101, "wait_d1_rst");
        load_valid = 1'b1;
        load_value = 16'h9999;
        load_lzs   = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("rst_mid_pending", load_ready, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_sel", digit_sel_n, 4'hF);
        chk("rst_mid_blank", seg_blank, 1);
        chk("rst_mid_ready", load_ready, 1);
        chk("rst_mid_fs", frame_start, 0);
        chk("rst_mid_nib", hex_nibble, 0);
        tick();
        reset = 1'b0;
        wait_fs("post_rst_fs1");
        check_frame(16'h0000, 4'b0000, "post_rst1");
        wait_fs("post_rst_fs2");
        check_frame(16'h0000, 4'b0000, "post_rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the vending machine's multi-digit seven-segment display.
- Sequences one shared hex-to-segment decoder across NUM_DIGITS common-anode digits.
- Double-buffers the displayed value with a valid/ready load handshake, so updates never tear mid-frame.
- Adds an anti-ghosting guard interval and leading-zero suppression.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; minimum 4.
- GUARD_CYCLES, 2: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- BLINK_FRAMES, 32: frames per blink half-period (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- disp_on  in  1  display enable; low = all digits dark
- load_valid  in  1  new value offered
- load_ready  out  1  controller can accept a value
- load_value  in  4*NUM_DIGITS  hex nibbles; nibble 0 = least significant digit
- load_lzs  in  1  leading-zero suppression for this value; captured with load_value
- blink_mask  in  NUM_DIGITS  per-digit blink select; ignored unless BLINK_EN
- hex_nibble  out  4  nibble sent to the shared decoder
- digit_sel_n  out  NUM_DIGITS  active-low anode enables; at most one bit low
- seg_blank  out  1  high = downstream forces all segments off
- frame_start  out  1  one-cycle pulse when digit 0's slot begins

Behaviour:
- Reset values: hex_nibble=0, digit_sel_n=all ones, seg_blank=1, frame_start=0, load_ready=1.
- Reset also clears: active buffer=0, active lzs=0, pending flag=0, idx=0, tick=0, frame count=0, state=IDLE.
- Reset applies mid-operation with the same result; any pending value is discarded.
- All outputs are registered. They reflect internal state one cycle later.
- States:
  - IDLE: disp_on=0. Anodes off, seg_blank=1, idx=0, tick=0.
  - GUARD: tick < GUARD_CYCLES. Anodes off, seg_blank=1, hex_nibble already shows the slot's nibble.
  - DRIVE: tick >= GUARD_CYCLES. digit_sel_n[idx]=0.
- Transitions:
  - IDLE -> GUARD when disp_on=1.
  - GUARD -> DRIVE when tick = GUARD_CYCLES-1.
  - DRIVE -> GUARD at tick = REFRESH_DIV-1. tick returns to 0; idx increments and wraps NUM_DIGITS-1 -> 0.
  - Any state -> IDLE on the cycle after disp_on=0. idx and tick reset; load handshake continues to operate.
- frame_start pulses when entering GUARD with idx=0, including the first slot after IDLE.
- Load handshake:
  - A transfer occurs on load_valid & load_ready. load_value and load_lzs go into the pending buffer; pending=1; load_ready=0 from the next cycle.
  - Pending is committed to the active buffer on the cycle idx wraps to 0, or on the next cycle if in IDLE.
  - pending clears and load_ready returns to 1 the cycle after commit.
  - load_value is never sampled while load_ready=0.
  - A transfer in the same cycle as a wrap commits at the following wrap, not the current one.
- Leading-zero suppression (active lzs=1):
  - Digit i is blanked if it and every digit above it are zero.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - A blanked digit drives seg_blank=1 during its DRIVE phase; its anode is still asserted (uniform duty).
- seg_blank=0 only in DRIVE for a non-suppressed (and non-blinked) digit.

Optional Feature:
- Macro: DISP_SCAN_BLINK_EN.
- Defined:
  - A frame counter counts frame_start pulses, wrapping at BLINK_FRAMES-1 and toggling a blink phase.
  - While phase=1, digits with blink_mask[i]=1 get seg_blank=1 in DRIVE.
  - Phase and counter reset to 0 on reset and on entry to IDLE.
- Not defined: blink_mask is ignored, no frame counter is synthesized, and behaviour is otherwise identical.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_FRAMES=2):
- Reset with disp_on=1 -> digit_sel_n=4'b1111 and seg_blank=1 during reset. The first frame_start comes 2 cycles after reset drops (registered IDLE->GUARD). digit_sel_n=4'b1110 for 6 cycles, then 4'b1111 for 2, then 4'b1101. Full frame period = 32 cycles.
- Load 16'h1234 with lzs=0 while idx=2 -> load_ready=0 until the wrap. After the wrap, hex_nibble sequence is 4,3,2,1 on digits 0..3. A second load_valid during pending is not accepted.
- Load 16'h0050 with lzs=1 -> digits 3 and 2 have seg_blank=1 in DRIVE; digits 1 and 0 show 5 and 0. Load 16'h0000 with lzs=1 -> only digit 0 unblanked.
- Drop disp_on mid-slot on digit 2 -> all anodes off the next output cycle. Raise disp_on -> scan restarts at digit 0 with a frame_start pulse. A pending load during IDLE commits within 2 cycles.
- Assert reset during DRIVE with pending=1 -> all outputs return to reset values; load_ready=1; active value 0.
- With DISP_SCAN_BLINK_EN and blink_mask=4'b0001 -> digit 0 is blanked for 2 frames, shown for 2 frames, and so on. Without the macro, digit 0 is always shown.
